// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Runs a multi-word add/subtract through one external 4-bit combinational
//   adder, one nibble per clock, least-significant nibble first. The carry
//   between nibbles is held in a register. Upstream uses start/busy/done.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request pulse, only sampled in IDLE
//   op_sub             0: a+b, 1: a-b (latched with start)
//   a, b               W-bit operands (latched with start)
//   busy               high in RUN and DONE
//   done               one-cycle pulse, result valid
//   result             sum/difference, held until the next accepted start
//   cout               final carry out (subtract: 1 = no borrow)
//   ovf                signed two's-complement overflow
//   zero               result == 0
//   add_i0/i1/cin      drive the external adder
//   add_sum/add_carry  sampled from the external adder
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic [3:0]           add_i0,
  output logic [3:0]           add_i1,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_r, b_r;
  logic          sub_r;
  logic          carry_r;
  logic [IW-1:0] idx;

  logic [3:0]    a_nib, b_nib;
  logic [W-1:0]  result_nxt;
  logic          accept;
  logic          last;
  logic          b_eff_msb;

  // Nibble selects and the result with the current nibble merged in; the
  // merged value lets the zero flag include the final nibble on the same edge.
  always_comb begin
    a_nib      = a_r[{idx, 2'b00} +: 4];
    b_nib      = b_r[{idx, 2'b00} +: 4];
    result_nxt = result;
    result_nxt[{idx, 2'b00} +: 4] = add_sum;
    b_eff_msb  = b_r[W-1] ^ sub_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_i0    = '0;
    add_i1    = '0;
    add_cin   = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_i0  = a_nib;
        add_i1  = b_nib ^ {4{sub_r}};
        add_cin = carry_r;
        if (idx == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      sub_r   <= op_sub;
      // Subtraction is a + ~b + 1: the +1 enters as the first carry-in.
      carry_r <= op_sub;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (state == RUN) begin
      result  <= result_nxt;
      carry_r <= add_carry;
      idx     <= idx + 1'b1;
      if (last) begin
        cout <= add_carry;
        ovf  <= (a_r[W-1] == b_eff_msb) && (add_sum[3] != a_r[W-1]);
        zero <= (result_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] result;
  logic [3:0]   add_i0, add_i1, add_sum;
  logic         add_cin, add_carry;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0] cyc_i1  [NIBBLES];
  logic       cyc_cin [NIBBLES];

  always #5 clk = ~clk;

  // External four_bit_full_adder
  assign {add_carry, add_sum} = {1'b0, add_i0} + {1'b0, add_i1} + {4'b0000, add_cin};

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero),
    .add_i0(add_i0), .add_i1(add_i1), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   full;
    be    = ts ? ~tbv : tbv;
    full  = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ts};
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
    e.z   = (full[W-1:0] == '0);
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after DONE
  // (DUT idle again). inject[0]: re-request with other operands mid-RUN;
  // inject[1]: request on the DONE cycle. Both must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic ts, input logic [1:0] inject);
    exp_t e;
    int   lat;
    sb.push_back(model(ta, tbv, ts));
    a = ta; b = tbv; op_sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (lat < NIBBLES) begin
        cyc_i1[lat]  = add_i1;
        cyc_cin[lat] = add_cin;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy_run: got %b expected 1 (cycle %0d)", busy, lat);
      end
      if (inject[0]) begin
        if (lat == 1) begin
          a = ~ta; b = ta ^ 16'h5A5A; op_sub = ~ts; start = 1'b1;
        end else if (lat == 2) begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != NIBBLES) begin
      errors++; $display("FAIL latency: got %0d expected %0d", lat, NIBBLES);
    end
    e = sb.pop_front();
    if (done === 1'b1) begin
      checks++;
      if (result !== e.res) begin
        errors++; $display("FAIL result: got %h expected %h", result, e.res);
      end
      checks++;
      if ({cout, ovf, zero} !== {e.c, e.v, e.z}) begin
        errors++; $display("FAIL flags(c,v,z): got %b%b%b expected %b%b%b",
                           cout, ovf, zero, e.c, e.v, e.z);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy_done: got %b expected 1", busy);
      end
      if (inject[1]) begin
        a = ~ta; b = ~tbv; op_sub = ~ts; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL idle_after_done(done,busy): got %b%b expected 00", done, busy);
      end
      checks++;
      if (result !== e.res || cout !== e.c) begin
        errors++; $display("FAIL result_held: got %h/%b expected %h/%b", result, cout, e.res, e.c);
      end
    end else begin
      errors++; $display("FAIL done_timeout: got done=%b expected 1", done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, cout, ovf, zero, add_i0, add_i1, add_cin} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b result=%h i0=%h i1=%h cin=%b expected all 0",
                         busy, done, result, add_i0, add_i1, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    run_op(16'h1234, 16'h0FFF, 1'b0, 2'b00);
  endtask

  task automatic test_carry_chain;
    logic [3:0] exp_i1  [4];
    logic       exp_cin [4];
    exp_i1  = '{4'h1, 4'h0, 4'h0, 4'h0};
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_op(16'hFFFF, 16'h0001, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cyc_i1[i] !== exp_i1[i] || cyc_cin[i] !== exp_cin[i]) begin
        errors++; $display("FAIL carry_cycle%0d(i1,cin): got %h,%b expected %h,%b",
                           i, cyc_i1[i], cyc_cin[i], exp_i1[i], exp_cin[i]);
      end
    end
  endtask

  task automatic test_sub_borrow;
    run_op(16'h0005, 16'h0007, 1'b1, 2'b00);
    checks++;
    if (cyc_i1[0] !== 4'h8 || cyc_cin[0] !== 1'b1) begin
      errors++; $display("FAIL sub_cycle0(i1,cin): got %h,%b expected 8,1", cyc_i1[0], cyc_cin[0]);
    end
  endtask

  task automatic test_overflow;
    run_op(16'h7FFF, 16'h0001, 1'b0, 2'b00);
    run_op(16'h8000, 16'h0001, 1'b1, 2'b00);
  endtask

  task automatic test_handshake;
    run_op(16'hA5C3, 16'h1111, 1'b0, 2'b11);
    // Starts in the cycle right after done must be accepted
    run_op(16'h0F0F, 16'h00F1, 1'b1, 2'b00);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 2'b00);
    end
  endtask

  task automatic test_reset_mid_op;
    a = 16'h4321; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_op_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cout, ovf, zero, add_i0, add_i1, add_cin} !== '0) begin
      errors++; $display("FAIL async_abort: got busy=%b done=%b result=%h i0=%h i1=%h cin=%b expected all 0",
                         busy, done, result, add_i0, add_i1, add_cin);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL no_done_after_abort: got %b expected 0", done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_sub_borrow();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
